// File: rtl/full_adder_8_bits_behavior.sv
// rtl/full_adder_8_bits_behavior.sv - 8-bit ripple-carry adder with optional output registers
//
// full_adder_behavior: one-bit full adder, SUM = A^B^CIN, COUT = majority(A,B,CIN).
// full_adder_8_bits_behavior: eight full_adder_behavior cells chained LSB to MSB.
//   CLK            rising-edge clock (used only when REGISTER_OUTPUTS != 0)
//   RST_N          asynchronous active-low reset, clears S/COUT/OVF
//   CIN            carry into bit 1
//   A1..A8, B1..B8 operands, bit 1 = LSB
//   S1..S8, COUT   sum and carry out of bit 8
//   OVF            signed overflow, present only with `define FA8_OVERFLOW_FLAG_EN
// Parameter REGISTER_OUTPUTS: 1 = one-cycle registered result, 0 = combinational.

module full_adder_behavior (
    input  logic CIN,
    input  logic A,
    input  logic B,
    output logic COUT,
    output logic SUM
);
    always_comb begin
        SUM  = A ^ B ^ CIN;
        COUT = (A & B) | (A & CIN) | (B & CIN);
    end
endmodule

module full_adder_8_bits_behavior #(
    parameter int unsigned REGISTER_OUTPUTS = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CIN,
    input  logic A1,
    input  logic B1,
    input  logic A2,
    input  logic B2,
    input  logic A3,
    input  logic B3,
    input  logic A4,
    input  logic B4,
    input  logic A5,
    input  logic B5,
    input  logic A6,
    input  logic B6,
    input  logic A7,
    input  logic B7,
    input  logic A8,
    input  logic B8,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic S4,
    output logic S5,
    output logic S6,
    output logic S7,
    output logic S8,
    output logic COUT
`ifdef FA8_OVERFLOW_FLAG_EN
    ,
    output logic OVF
`endif
);
    logic [7:0] a_vec;
    logic [7:0] b_vec;
    logic [8:0] carry;
    logic [7:0] sum_raw;
    logic [7:0] sum_d;
    logic       cout_d;
    logic [7:0] sum_out;
    logic       cout_out;

    assign a_vec    = {A8, A7, A6, A5, A4, A3, A2, A1};
    assign b_vec    = {B8, B7, B6, B5, B4, B3, B2, B1};
    assign carry[0] = CIN;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_bit
            full_adder_behavior u_fa (
                .CIN  (carry[i]),
                .A    (a_vec[i]),
                .B    (b_vec[i]),
                .COUT (carry[i+1]),
                .SUM  (sum_raw[i])
            );
        end
    endgenerate

    always_comb begin
        sum_d  = sum_raw;
        cout_d = carry[8];
    end

`ifdef FA8_OVERFLOW_FLAG_EN
    logic ovf_d;
    logic ovf_out;

    // Same-sign operands producing a result of the opposite sign.
    always_comb begin
        ovf_d = (a_vec[7] == b_vec[7]) && (sum_d[7] != a_vec[7]);
    end
`endif

    generate
        if (REGISTER_OUTPUTS != 0) begin : g_reg
            logic [7:0] sum_q;
            logic       cout_q;
`ifdef FA8_OVERFLOW_FLAG_EN
            logic       ovf_q;
`endif

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    sum_q  <= 8'h00;
                    cout_q <= 1'b0;
`ifdef FA8_OVERFLOW_FLAG_EN
                    ovf_q  <= 1'b0;
`endif
                end else begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
`ifdef FA8_OVERFLOW_FLAG_EN
                    ovf_q  <= ovf_d;
`endif
                end
            end

            assign sum_out  = sum_q;
            assign cout_out = cout_q;
`ifdef FA8_OVERFLOW_FLAG_EN
            assign ovf_out  = ovf_q;
`endif
        end else begin : g_comb
            assign sum_out  = sum_d;
            assign cout_out = cout_d;
`ifdef FA8_OVERFLOW_FLAG_EN
            assign ovf_out  = ovf_d;
`endif
        end
    endgenerate

    assign {S8, S7, S6, S5, S4, S3, S2, S1} = sum_out;
    assign COUT = cout_out;
`ifdef FA8_OVERFLOW_FLAG_EN
    assign OVF  = ovf_out;
`endif

endmodule

// File: tb/tb_full_adder_8_bits_behavior.sv
// tb/tb_full_adder_8_bits_behavior.sv - self-checking bench for full_adder_8_bits_behavior

module tb_full_adder_8_bits_behavior;

    logic       clk;
    logic       rst_n;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    wire  [7:0] s;
    wire        cout;
`ifdef FA8_OVERFLOW_FLAG_EN
    wire        ovf;
`endif

    logic fa_cin;
    logic fa_a;
    logic fa_b;
    wire  fa_cout;
    wire  fa_sum;

    int checks = 0;
    int errors = 0;

    full_adder_8_bits_behavior #(.REGISTER_OUTPUTS(1)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .CIN   (cin),
        .A1 (a[0]), .B1 (b[0]),
        .A2 (a[1]), .B2 (b[1]),
        .A3 (a[2]), .B3 (b[2]),
        .A4 (a[3]), .B4 (b[3]),
        .A5 (a[4]), .B5 (b[4]),
        .A6 (a[5]), .B6 (b[5]),
        .A7 (a[6]), .B7 (b[6]),
        .A8 (a[7]), .B8 (b[7]),
        .S1 (s[0]), .S2 (s[1]), .S3 (s[2]), .S4 (s[3]),
        .S5 (s[4]), .S6 (s[5]), .S7 (s[6]), .S8 (s[7]),
        .COUT  (cout)
`ifdef FA8_OVERFLOW_FLAG_EN
        ,
        .OVF   (ovf)
`endif
    );

    full_adder_behavior u_fa (
        .CIN  (fa_cin),
        .A    (fa_a),
        .B    (fa_b),
        .COUT (fa_cout),
        .SUM  (fa_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact unsigned 9-bit sum.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[8:0];
    endfunction

    // Reference: signed result outside the 8-bit two's-complement range.
    function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
        int total;
        total = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (total > 127) || (total < -128);
    endfunction

    // Drive at a falling edge, let one rising edge capture, check at the next falling edge.
    task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
        a   = x;
        b   = y;
        cin = c;
        @(posedge clk);
        @(negedge clk);
        check(tag, {cout, s}, model(x, y, c));
`ifdef FA8_OVERFLOW_FLAG_EN
        check({tag, "_ovf"}, {8'h00, ovf}, {8'h00, model_ovf(x, y, c)});
`endif
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;
        logic       rc;
        logic [2:0] combo;

        rst_n = 1'b0;
        cin   = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        fa_cin = 1'b0;
        fa_a   = 1'b0;
        fa_b   = 1'b0;

        // Full-adder truth table.
        for (int k = 0; k < 8; k++) begin
            combo  = 3'(k);
            fa_cin = combo[2];
            fa_a   = combo[1];
            fa_b   = combo[0];
            #1;
            check("fa_unit", {7'h00, fa_cout, fa_sum}, 9'(int'(combo[2]) + int'(combo[1]) + int'(combo[0])));
        end

        // Outputs held at zero while reset is asserted, even across clock edges.
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_state", {cout, s}, 9'h000);

        rst_n = 1'b1;
        step("ff_plus_00", 8'hFF, 8'h00, 1'b0);
        check("ff_plus_00_const", {cout, s}, 9'h0FF);
        step("88_plus_26", 8'h88, 8'h26, 1'b0);
        check("88_plus_26_const", {cout, s}, 9'h0AE);
        step("98_plus_36", 8'h98, 8'h36, 1'b0);
        check("98_plus_36_const", {cout, s}, 9'h0CE);
        step("c3_plus_3c", 8'hC3, 8'h3C, 1'b0);
        check("c3_plus_3c_const", {cout, s}, 9'h0FF);
        step("c3_plus_3c_cin", 8'hC3, 8'h3C, 1'b1);
        check("c3_plus_3c_cin_const", {cout, s}, 9'h100);
        step("ff_plus_01", 8'hFF, 8'h01, 1'b0);
        check("ff_plus_01_const", {cout, s}, 9'h100);
        step("ff_plus_ff_cin", 8'hFF, 8'hFF, 1'b1);
        check("ff_plus_ff_cin_const", {cout, s}, 9'h1FF);
        step("7f_plus_01", 8'h7F, 8'h01, 1'b0);
        check("7f_plus_01_const", {cout, s}, 9'h080);

        // Input changes alone must not move registered outputs.
        a = 8'h12; b = 8'h34; cin = 1'b1;
        #2;
        check("hold_no_edge", {cout, s}, 9'h080);

        // Reset between clocks: immediate clear, pending result discarded.
        @(negedge clk);
        a = 8'h55; b = 8'h55; cin = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {cout, s}, 9'h000);
        @(posedge clk);
        @(negedge clk);
        check("reset_ignores_edge", {cout, s}, 9'h000);
        rst_n = 1'b1;
        #1;
        check("release_no_stale", {cout, s}, 9'h000);
        @(posedge clk);
        @(negedge clk);
        check("release_capture", {cout, s}, 9'h0AA);

        // Random vectors, one new operand set every cycle.
        for (int k = 0; k < 40; k++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            step("random", rx, ry, rc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
